// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: reverse AES key schedule, streams round keys Nr..0 one per emit cycle
// Ports: clk, reset_n (sync, active-low), start/last_key (request + final Nk words of the expanded key),
//        busy, rk_valid/rk_round/round_key (descending round-key stream), done (one-cycle end pulse).
// The S-box computes the GF(2^8) inverse as a^254, then applies the AES affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, y;
    p = 8'h00;
    y = a;
    for (int n = 0; n < 8; n++) begin
      p = b[n] ? p ^ y : p;
      y = {y[6:0], 1'b0} ^ (y[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, y;
    r = 8'h01;
    y = a;
    for (int n = 0; n < 7; n++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r;
  endfunction
  logic [7:0] v;
  assign v = ginv(a_i);
  assign s_o = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_schedule #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [32*Nk-1:0]   last_key,
  output logic               busy,
  output logic               rk_valid,
  output logic [3:0]         rk_round,
  output logic [127:0]       round_key,
  output logic               done
);
  localparam int Nb = 4;
  localparam int KEY_SIZE = 32 * Nk;
  localparam int TOTAL_WORDS = Nb * (Nr + 1);
  localparam int J0 = TOTAL_WORDS - Nk;
  localparam int P0 = (TOTAL_WORDS - 1) % Nk;
  localparam int Q0 = (TOTAL_WORDS - 1) / Nk;
  localparam logic [7:0] RCON [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q;
  // Window word 0 (MSB) is w[j]; p_q/q_q track i mod Nk and i / Nk for i = j+Nk-1.
  logic [KEY_SIZE-1:0] win_q, win_d;
  logic [5:0] j_q, off;
  logic [3:0] r_q, q_q, q_d;
  logic [2:0] p_q, p_d;
  logic emit, rot;
  logic [31:0] x, t, sw_in, sw_out;
  logic [127:0] sel;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sb (.a_i(sw_in[8*g +: 8]), .s_o(sw_out[8*g +: 8]));
  end
  assign emit = {r_q, 2'b00} >= j_q;
  assign off = {r_q, 2'b00} - j_q;
  assign rot = p_q == 3'd0;
  assign x = win_q[63:32];
  assign sw_in = rot ? {x[23:0], x[31:24]} : x;
  assign t = rot ? sw_out ^ {RCON[q_q], 24'h0} : (Nk > 6 && p_q == 3'd4) ? sw_out : x;
  assign win_d = {win_q[31:0] ^ t, win_q[KEY_SIZE-1:32]};
  assign p_d = rot ? 3'(Nk - 1) : p_q - 3'd1;
  assign q_d = rot ? q_q - 4'd1 : q_q;
  always_comb begin
    sel = '0;
    for (int o = 0; o <= Nk - 4; o++) sel = (off == 6'(o)) ? win_q[KEY_SIZE-1-32*o -: 128] : sel;
  end
  // Outputs are registered, so the start edge itself performs the first emit (round Nr is the
  // low four words of last_key); every later edge performs the action seen one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy <= 1'b0;
      rk_valid <= 1'b0;
      done <= 1'b0;
      rk_round <= '0;
      round_key <= '0;
      win_q <= '0;
      j_q <= '0;
      r_q <= '0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          rk_valid <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy <= 1'b1;
            rk_valid <= 1'b1;
            rk_round <= 4'(Nr);
            round_key <= last_key[127:0];
            win_q <= last_key;
            j_q <= 6'(J0);
            r_q <= 4'(Nr - 1);
            p_q <= 3'(P0);
            q_q <= 4'(Q0);
          end
        end
        RUN: begin
          rk_valid <= emit;
          if (emit) begin
            rk_round <= r_q;
            round_key <= sel;
            r_q <= r_q - 4'd1;
            if (r_q == 4'd0) state_q <= FIN;
          end else begin
            win_q <= win_d;
            j_q <= j_q - 6'd1;
            p_q <= p_d;
            q_q <= q_d;
          end
        end
        FIN: begin
          rk_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: scoreboard bench for the reverse key schedule at Nk = 4, 6, 8
module tb_aes_inv_key_schedule;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, s4, s6, s8;
  logic [127:0] lk4;
  logic [191:0] lk6;
  logic [255:0] lk8;
  logic b4, v4, d4, b6, v6, d6, b8, v8, d8;
  logic [3:0] r4, r6, r8;
  logic [127:0] k4, k6, k8;
  int total = 0, bad = 0;
  logic [131:0] q4[$], q6[$], q8[$];
  logic [131:0] e4, e6, e8;
  logic [127:0] cap4[16], cap6[16], cap8[16];
  logic [7:0] sb[256], ex[256], lg[256];
  logic [31:0] w[60];

  aes_inv_key_schedule #(.Nk(4), .Nr(10)) u4 (.clk(clk), .reset_n(reset_n), .start(s4), .last_key(lk4),
    .busy(b4), .rk_valid(v4), .rk_round(r4), .round_key(k4), .done(d4));
  aes_inv_key_schedule #(.Nk(6), .Nr(12)) u6 (.clk(clk), .reset_n(reset_n), .start(s6), .last_key(lk6),
    .busy(b6), .rk_valid(v6), .rk_round(r6), .round_key(k6), .done(d6));
  aes_inv_key_schedule #(.Nk(8), .Nr(14)) u8 (.clk(clk), .reset_n(reset_n), .start(s8), .last_key(lk8),
    .busy(b8), .rk_valid(v8), .rk_round(r8), .round_key(k8), .done(d8));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] a);
    return {sb[a[31:24]], sb[a[23:16]], sb[a[15:8]], sb[a[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] p, v;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = 8'(i);
      p = p ^ xt(p);
    end
    sb[0] = 8'h63;
    for (int a = 1; a < 256; a++) begin
      v = ex[(255 - int'(lg[a])) % 255];
      sb[a] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int c = 1; c < i / nk; c++) rc = xt(rc);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [134:0] outs(input int nk);
    return nk == 4 ? {b4, v4, d4, r4, k4} : nk == 6 ? {b6, v6, d6, r6, k6} : {b8, v8, d8, r8, k8};
  endfunction

  function automatic int qsz(input int nk);
    return nk == 4 ? q4.size() : nk == 6 ? q6.size() : q8.size();
  endfunction

  always @(negedge clk) if (v4) begin
    if (q4.size() == 0) chk("n4_extra_beat", 1, 0);
    else begin
      e4 = q4.pop_front();
      chk("n4_round", r4, e4[131:128]);
      chk("n4_key", k4, e4[127:0]);
      cap4[r4] = k4;
    end
  end
  always @(negedge clk) if (v6) begin
    if (q6.size() == 0) chk("n6_extra_beat", 1, 0);
    else begin
      e6 = q6.pop_front();
      chk("n6_round", r6, e6[131:128]);
      chk("n6_key", k6, e6[127:0]);
      cap6[r6] = k6;
    end
  end
  always @(negedge clk) if (v8) begin
    if (q8.size() == 0) chk("n8_extra_beat", 1, 0);
    else begin
      e8 = q8.pop_front();
      chk("n8_round", r8, e8[131:128]);
      chk("n8_key", k8, e8[127:0]);
      cap8[r8] = k8;
    end
  end

  // rp: re-pulse start (with a corrupted key) mid-run; rb: assert reset at that beat number.
  task automatic run(input int nk, input logic [255:0] key, input bit rp, input int rb);
    int nr, tot, n, nb, nbu;
    logic [255:0] lk;
    logic [134:0] o;
    logic [131:0] e;
    bit ab, fin;
    nr = nk + 6;
    tot = 4 * (nr + 1);
    expand(nk, key);
    lk = '0;
    for (int m = 0; m < nk; m++) lk[255-32*m -: 32] = w[tot-nk+m];
    for (int r = nr; r >= 0; r--) begin
      e = {4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (nk == 4) q4.push_back(e);
      else if (nk == 6) q6.push_back(e);
      else q8.push_back(e);
    end
    @(negedge clk);
    if (nk == 4) begin lk4 = lk[255 -: 128]; s4 = 1'b1; end
    else if (nk == 6) begin lk6 = lk[255 -: 192]; s6 = 1'b1; end
    else begin lk8 = lk; s8 = 1'b1; end
    n = 0; nb = 0; nbu = 0; ab = 0; fin = 0; o = '0;
    while (!fin && !ab && n < 200) begin
      @(negedge clk);
      n++;
      s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
      o = outs(nk);
      if (n == 1) chk($sformatf("n%0d_first_beat", nk), {o[134:133], o[131:128]}, {2'b11, 4'(nr)});
      if (nk == 8 && n == 2) chk("n8_back_to_back", {o[133], o[131:128]}, {1'b1, 4'd13});
      if (nk == 6 && n == 2) chk("n6_step_gap", o[133], 0);
      nbu += int'(o[134]);
      nb += int'(o[133]);
      fin = o[132];
      if (rp && n == 10) begin lk4 = ~lk4; s4 = 1'b1; end
      if (rb != 0 && o[133] && nb == rb) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk($sformatf("n%0d_mid_reset_outs", nk), outs(nk), 0);
        reset_n = 1'b1;
        q4.delete(); q6.delete(); q8.delete();
        ab = 1;
      end
    end
    if (!ab) begin
      chk($sformatf("n%0d_done_cycle", nk), n, tot - nk + nr + 2);
      chk($sformatf("n%0d_busy_at_done", nk), o[134], 0);
      chk($sformatf("n%0d_beats", nk), nb, nr + 1);
      chk($sformatf("n%0d_busy_cycles", nk), nbu, tot - nk + nr + 1);
      chk($sformatf("n%0d_sb_empty", nk), qsz(nk), 0);
    end
  endtask

  initial begin
    logic [255:0] rk;
    build_sbox();
    reset_n = 1'b0;
    s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
    lk4 = '0; lk6 = '0; lk8 = '0;
    repeat (2) @(negedge clk);
    chk("n4_reset", outs(4), 0);
    chk("n6_reset", outs(6), 0);
    chk("n8_reset", outs(8), 0);
    reset_n = 1'b1;
    run(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 0);
    chk("n4_r10", cap4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("n4_r9", cap4[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("n4_r0", cap4[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, 0);
    chk("n8_r0", cap8[0], 128'h000102030405060708090a0b0c0d0e0f);
    run(6, 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000, 0, 0);
    chk("n6_r0", cap6[0], 128'h000102030405060708090a0b0c0d0e0f);
    run(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1, 0);
    run(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 5);
    cap4[10] = '0;
    run(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 0);
    chk("n4_r10_after_reset", cap4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int t = 0; t < 120; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(4 + 2 * (t % 3), rk, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
